xfft_tw_gen: RTL
================

XFFT_TW_GEN -- requirements
Module: xfft_tw_gen

Interface
REQ-001 SHALL have parameter NB_I, default 8, data word width.
REQ-002 SHALL have parameter NBF_I, default 7, data fractional bits.
REQ-003 SHALL have parameter NB_T, default 10, twiddle word width.
REQ-004 SHALL have parameter NBF_T, default 9, twiddle fractional bits.
REQ-005 SHALL have parameter N_FFT, default 16, FFT size (power of two, >=8); LOG2_N = log2(N_FFT).
REQ-006 SHALL have port i_clk, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have ports i_valid, input, 1, sample strobe; and i_sof, input, 1, first sample of frame.
REQ-009 SHALL have port i_step, input, LOG2_N, twiddle exponent stride, latched on accepted SOF.
REQ-010 SHALL have ports i_data_r and i_data_i, input, NB_I signed, sample.
REQ-011 SHALL have ports o_data_r and o_data_i, output, NB_I signed, delayed sample.
REQ-012 SHALL have ports o_tw_r and o_tw_i, output, NB_T signed, twiddle aligned to o_data.
REQ-013 SHALL have ports o_valid, o_sof, o_eof, o_err, outputs, 1 each; these feed the complex-multiplier cell's valid/data/twiddle inputs directly.

Function
REQ-014 SHALL use FSM states IDLE and RUN; IDLE->RUN on i_valid&i_sof; RUN->IDLE on accepted sample with index N_FFT-1 and no SOF.
REQ-015 SHALL, in IDLE, drop i_valid samples with i_sof=0 (no o_valid, no o_err).
REQ-016 SHALL keep sample index n: 0 on accepted SOF, +1 per accepted sample; unchanged on i_valid=0 gaps; no backpressure, at most one sample per cycle.
REQ-017 SHALL, on i_valid&i_sof in RUN, restart at n=0, relatch i_step, and pulse o_err one cycle aligned with that sample's output.
REQ-018 SHALL compute exponent e = (n * step) mod N_FFT (low LOG2_N bits of product).
REQ-019 SHALL output W^e = cos(2*pi*e/N) - j*sin(2*pi*e/N), quantized as c(m) = round(cos(2*pi*m/N)*2^NBF_T) for m=0..N/4, with c(0) saturated to 2^(NB_T-1)-1.
REQ-020 SHALL form twiddle from quadrant q = e[LOG2_N-1:LOG2_N-2], r = low bits: q0 (c(r), -c(N/4-r)); q1 (-c(N/4-r), -c(r)); q2 (-c(r), c(N/4-r)); q3 (c(N/4-r), c(r)).
REQ-021 SHALL have latency 2 cycles from accepted input to o_valid, data and twiddle aligned on the same cycle.
REQ-022 SHALL assert o_sof with output of n=0 and o_eof with output of n=N_FFT-1, each one cycle.
REQ-023 SHALL pass o_data_r/o_data_i through bit-exact.

Reset
REQ-024 SHALL, while i_rst_n=0, force FSM to IDLE, n to 0, latched step to 0, all pipeline valids to 0, and all outputs to 0.
REQ-025 SHALL discard in-flight samples on reset mid-frame; first post-reset output requires a new SOF.

Configuration
REQ-026 SHALL honour macro XFFT_TW_GEN_OREG_EN: defined adds one output register stage (latency 3, all outputs including o_err/o_sof/o_eof delayed equally); undefined gives latency 2.

Structure
REQ-027 SHALL place LOG2_N derivation function, FSM state encodings and quadrant encodings in shared package xfft_pkg.
REQ-028 SHALL implement the N/4+1-entry quarter-wave table as sub-module xfft_tw_rom (address m, output c(m), NB_T signed).

Verification
REQ-029 SHALL check: N=16, step=1, 16 contiguous samples -> n=0 (511,0), n=2 (362,-362), n=4 (0,-511), n=8 (-511,0), n=12 (0,511); o_eof with n=15; latency 2.
REQ-030 SHALL check: step=3, sample n=5 -> e=15 -> twiddle (473,196).
REQ-031 SHALL check: i_valid gaps of 1-3 cycles inside frame -> indices continuous, outputs only on accepted samples; i_valid without SOF in IDLE -> no output.
REQ-032 SHALL check: SOF at n=7 in RUN -> o_err one cycle, that sample output twiddle (511,0), o_sof asserted, frame completes 16 samples later.
REQ-033 SHALL check: i_rst_n low mid-frame -> outputs 0 asynchronously, next non-SOF samples dropped.
REQ-034 SHALL check: with XFFT_TW_GEN_OREG_EN defined, scenario REQ-029 yields identical values at latency 3.

Source files
------------

// File: rtl/xfft_pkg.sv
// Shared definitions for the FFT twiddle generator: FSM and quadrant encodings,
// log2 helper and the quantised quarter-wave cosine used to build the ROM.
package xfft_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } xfft_state_e;

  typedef enum logic [1:0] {
    QD_0 = 2'd0,
    QD_1 = 2'd1,
    QD_2 = 2'd2,
    QD_3 = 2'd3
  } xfft_quad_e;

  function automatic int xfft_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // round(cos(2*pi*m/n) * 2^nbf), clipped to the largest positive nb-bit value
  function automatic int xfft_tw_cos(input int m, input int n, input int nbf, input int nb);
    real ang;
    real scaled;
    int  v;
    int  vmax;
    ang    = 2.0 * 3.14159265358979323846 * $itor(m) / $itor(n);
    scaled = $cos(ang) * $itor(1 << nbf);
    v      = $rtoi(scaled + 0.5);
    vmax   = (1 << (nb - 1)) - 1;
    if (v > vmax) v = vmax;
    return v;
  endfunction

endpackage

// File: rtl/xfft_tw_rom.sv
// Quarter-wave cosine table c(0..N/4); entries are elaboration-time constants.
module xfft_tw_rom
  import xfft_pkg::*;
#(
  parameter int N_FFT = 16,
  parameter int NB_T  = 10,
  parameter int NBF_T = 9,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]          i_addr,
  output logic signed [NB_T-1:0] o_c
);

  localparam int DEPTH = N_FFT / 4 + 1;

  logic signed [NB_T-1:0] tbl [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    assign tbl[g] = NB_T'(xfft_tw_cos(g, N_FFT, NBF_T, NB_T));
  end

  always_comb begin
    o_c = '0;
    if (int'(i_addr) < DEPTH) o_c = tbl[i_addr];
  end

endmodule

// File: rtl/xfft_tw_gen.sv
// Twiddle generator: tags each accepted sample with W^((n*step) mod N), 2-cycle latency.
// Define XFFT_TW_GEN_OREG_EN to add one output register stage (latency 3).
module xfft_tw_gen
  import xfft_pkg::*;
#(
  parameter int NB_I   = 8,
  parameter int NBF_I  = 7,
  parameter int NB_T   = 10,
  parameter int NBF_T  = 9,
  parameter int N_FFT  = 16,
  localparam int LOG2_N = xfft_log2(N_FFT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [LOG2_N-1:0]      i_step,
  input  logic signed [NB_I-1:0] i_data_r,
  input  logic signed [NB_I-1:0] i_data_i,
  output logic signed [NB_I-1:0] o_data_r,
  output logic signed [NB_I-1:0] o_data_i,
  output logic signed [NB_T-1:0] o_tw_r,
  output logic signed [NB_T-1:0] o_tw_i,
  output logic                   o_valid,
  output logic                   o_sof,
  output logic                   o_eof,
  output logic                   o_err,
  output xfft_state_e            o_dbg_state
);

  // Handshake: no backpressure. A sample moves when i_valid is high on a rising
  // edge and the FSM accepts it; o_valid marks each output cycle, one per sample.

  localparam int AW = LOG2_N - 1;
  localparam logic [LOG2_N-1:0] N_LAST = LOG2_N'(N_FFT - 1);
  localparam logic [AW-1:0]     A_QTR  = AW'(N_FFT / 4);

  if (N_FFT < 8 || (N_FFT & (N_FFT - 1)) != 0) begin : g_bad_n
    $error("xfft_tw_gen: N_FFT must be a power of two >= 8");
  end
  if (NBF_I >= NB_I || NBF_T >= NB_T) begin : g_bad_frac
    $error("xfft_tw_gen: fractional bits must be below word width");
  end

  xfft_state_e       state_q, state_d;
  logic [LOG2_N-1:0] n_q, n_d;
  logic [LOG2_N-1:0] step_q, step_d;
  logic              accept;
  logic              err_pulse;
  logic [LOG2_N-1:0] idx;
  logic [LOG2_N-1:0] stp;
  logic [LOG2_N-1:0] e0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid && i_sof) state_d = ST_RUN;
      ST_RUN:  if (i_valid && !i_sof && n_q == N_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside a frame only an SOF is taken; an SOF inside a frame restarts it and flags o_err
  always_comb begin
    accept    = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      ST_IDLE: accept = i_valid & i_sof;
      ST_RUN: begin
        accept    = i_valid;
        err_pulse = i_valid & i_sof;
      end
      default: ;
    endcase
  end

  // The SOF sample uses index 0 and the incoming stride before they are latched
  always_comb begin
    idx    = i_sof ? '0 : n_q;
    stp    = i_sof ? i_step : step_q;
    e0     = idx * stp;
    n_d    = accept ? idx + LOG2_N'(1) : n_q;
    step_d = (accept && i_sof) ? i_step : step_q;
  end

  logic                   v1_q, sof1_q, eof1_q, err1_q;
  logic signed [NB_I-1:0] dr1_q, di1_q;
  logic [LOG2_N-1:0]      e1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      eof1_q <= 1'b0;
      err1_q <= 1'b0;
      dr1_q  <= '0;
      di1_q  <= '0;
      e1_q   <= '0;
    end else begin
      v1_q   <= accept;
      sof1_q <= accept & i_sof;
      eof1_q <= accept & (idx == N_LAST);
      err1_q <= err_pulse;
      if (accept) begin
        dr1_q <= i_data_r;
        di1_q <= i_data_i;
        e1_q  <= e0;
      end
    end
  end

  xfft_quad_e             quad;
  logic [AW-1:0]          addr_a, addr_b;
  logic signed [NB_T-1:0] ca, cb;
  logic signed [NB_T-1:0] tw_r_d, tw_i_d;

  assign quad   = xfft_quad_e'(e1_q[LOG2_N-1 -: 2]);
  assign addr_a = {1'b0, e1_q[LOG2_N-3:0]};
  assign addr_b = A_QTR - addr_a;

  xfft_tw_rom #(.N_FFT(N_FFT), .NB_T(NB_T), .NBF_T(NBF_T), .AW(AW)) u_rom_a (
    .i_addr (addr_a),
    .o_c    (ca)
  );

  xfft_tw_rom #(.N_FFT(N_FFT), .NB_T(NB_T), .NBF_T(NBF_T), .AW(AW)) u_rom_b (
    .i_addr (addr_b),
    .o_c    (cb)
  );

  // Unfold the quarter wave: ca = c(r), cb = c(N/4-r)
  always_comb begin
    tw_r_d = ca;
    tw_i_d = -cb;
    case (quad)
      QD_0: begin tw_r_d = ca;  tw_i_d = -cb; end
      QD_1: begin tw_r_d = -cb; tw_i_d = -ca; end
      QD_2: begin tw_r_d = -ca; tw_i_d = cb;  end
      QD_3: begin tw_r_d = cb;  tw_i_d = ca;  end
      default: ;
    endcase
  end

  logic                   v2_q, sof2_q, eof2_q, err2_q;
  logic signed [NB_I-1:0] dr2_q, di2_q;
  logic signed [NB_T-1:0] tr2_q, ti2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eof2_q <= 1'b0;
      err2_q <= 1'b0;
      dr2_q  <= '0;
      di2_q  <= '0;
      tr2_q  <= '0;
      ti2_q  <= '0;
    end else begin
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
      eof2_q <= eof1_q;
      err2_q <= err1_q;
      if (v1_q) begin
        dr2_q <= dr1_q;
        di2_q <= di1_q;
        tr2_q <= tw_r_d;
        ti2_q <= tw_i_d;
      end
    end
  end

`ifdef XFFT_TW_GEN_OREG_EN
  logic                   v3_q, sof3_q, eof3_q, err3_q;
  logic signed [NB_I-1:0] dr3_q, di3_q;
  logic signed [NB_T-1:0] tr3_q, ti3_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v3_q   <= 1'b0;
      sof3_q <= 1'b0;
      eof3_q <= 1'b0;
      err3_q <= 1'b0;
      dr3_q  <= '0;
      di3_q  <= '0;
      tr3_q  <= '0;
      ti3_q  <= '0;
    end else begin
      v3_q   <= v2_q;
      sof3_q <= sof2_q;
      eof3_q <= eof2_q;
      err3_q <= err2_q;
      if (v2_q) begin
        dr3_q <= dr2_q;
        di3_q <= di2_q;
        tr3_q <= tr2_q;
        ti3_q <= ti2_q;
      end
    end
  end

  assign o_valid  = v3_q;
  assign o_sof    = sof3_q;
  assign o_eof    = eof3_q;
  assign o_err    = err3_q;
  assign o_data_r = dr3_q;
  assign o_data_i = di3_q;
  assign o_tw_r   = tr3_q;
  assign o_tw_i   = ti3_q;
`else
  assign o_valid  = v2_q;
  assign o_sof    = sof2_q;
  assign o_eof    = eof2_q;
  assign o_err    = err2_q;
  assign o_data_r = dr2_q;
  assign o_data_i = di2_q;
  assign o_tw_r   = tr2_q;
  assign o_tw_i   = ti2_q;
`endif

  assign o_dbg_state = state_q;

endmodule
